// File: rtl/pc_gen.sv
// Program-counter generator feeding fetch_imem: sequential +4 advance, stall,
// redirect, halt/resume, sticky address faults and a retired-fetch counter.
module pc_gen #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          IMEM_LOG2  = 3,
    parameter logic        WRAP_EN    = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    input  logic        halt_req_i,
    input  logic        resume_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        pc_valid_o,
    output logic        fault_misalign_o,
    output logic        fault_range_o,
    output logic [31:0] fetch_count_o
);

    localparam logic [31:0] LIMIT = 32'd4 << IMEM_LOG2;

    typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fm_q, fm_d;
    logic        fr_q, fr_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pc_plus4;
    logic        seq_oor;

    assign pc_plus4 = pc_q + 32'd4;
    assign seq_oor  = (pc_plus4 >= LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BOOT;
            pc_q    <= RESET_ADDR;
            fm_q    <= 1'b0;
            fr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fm_q    <= fm_d;
            fr_q    <= fr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fm_d    = fm_q;
        fr_d    = fr_q;
        cnt_d   = cnt_q;
        // Retired fetch is counted on the current state, before any transition.
        if (state_q == RUN && !stall_i) cnt_d = cnt_q + 32'd1;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (halt_req_i) begin
                    state_d = HALT;
                end else if (redirect_valid_i) begin
                    if (redirect_target_i[1:0] != 2'b00) begin
                        state_d = FAULT;
                        fm_d    = 1'b1;
                    end else if (redirect_target_i >= LIMIT) begin
                        state_d = FAULT;
                        fr_d    = 1'b1;
                    end else begin
                        pc_d = redirect_target_i;
                    end
                end else if (!stall_i) begin
                    if (!seq_oor)     pc_d = pc_plus4;
                    else if (WRAP_EN) pc_d = RESET_ADDR;
                    else begin
                        state_d = FAULT;
                        fr_d    = 1'b1;
                    end
                end
            end
            HALT: begin
                // A halt request arriving alongside resume keeps us parked.
                if (resume_i && !halt_req_i) begin
                    state_d = RUN;
                    if (!seq_oor)     pc_d = pc_plus4;
                    else if (WRAP_EN) pc_d = RESET_ADDR;
                    else begin
                        state_d = FAULT;
                        fr_d    = 1'b1;
                    end
                end
            end
            FAULT: state_d = FAULT;
            default: state_d = BOOT;
        endcase
    end

    assign pc_o             = pc_q;
    assign pc_plus4_o       = pc_plus4;
    assign pc_valid_o       = (state_q == RUN);
    assign fault_misalign_o = fm_q;
    assign fault_range_o    = fr_q;
    assign fetch_count_o    = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed table-driven bench for pc_gen, plus a hand sequence for the wrapping build.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst, stall, rv, halt, resume;
    logic [31:0] tgt;

    logic [31:0] pc, pc4, cnt;
    logic        vld, fm, fr;
    logic [31:0] w_pc, w_pc4, w_cnt;
    logic        w_vld, w_fm, w_fr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_gen #(.RESET_ADDR(32'h0), .IMEM_LOG2(3), .WRAP_EN(1'b0)) u_dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_valid_i(rv),
        .redirect_target_i(tgt), .halt_req_i(halt), .resume_i(resume),
        .pc_o(pc), .pc_plus4_o(pc4), .pc_valid_o(vld),
        .fault_misalign_o(fm), .fault_range_o(fr), .fetch_count_o(cnt)
    );

    pc_gen #(.RESET_ADDR(32'h0), .IMEM_LOG2(3), .WRAP_EN(1'b1)) u_wrap (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_valid_i(rv),
        .redirect_target_i(tgt), .halt_req_i(halt), .resume_i(resume),
        .pc_o(w_pc), .pc_plus4_o(w_pc4), .pc_valid_o(w_vld),
        .fault_misalign_o(w_fm), .fault_range_o(w_fr), .fetch_count_o(w_cnt)
    );

    typedef struct {
        logic        rst, stall, rv, halt, resume;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic        e_vld, e_fm, e_fr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, s, v, input logic [31:0] t, input logic h, re,
                       input logic [31:0] ep, input logic ev, efm, efr,
                       input logic [31:0] ec);
        vec_t x;
        x.rst = r; x.stall = s; x.rv = v; x.tgt = t; x.halt = h; x.resume = re;
        x.e_pc = ep; x.e_vld = ev; x.e_fm = efm; x.e_fr = efr; x.e_cnt = ec;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, s, v, input logic [31:0] t, input logic h, re);
        rst = r; stall = s; rv = v; tgt = t; halt = h; resume = re;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; rv = 1'b0; tgt = '0; halt = 1'b0; resume = 1'b0;

        //   rst s  rv tgt      h  re   pc       vld fm fr cnt
        add(1, 0, 0, 32'h00, 0, 0,   32'h00, 0, 0, 0, 0);  // 0 reset
        add(1, 0, 0, 32'h00, 0, 0,   32'h00, 0, 0, 0, 0);  // 1
        add(0, 0, 0, 32'h00, 0, 0,   32'h00, 1, 0, 0, 0);  // 2 BOOT->RUN
        add(0, 0, 0, 32'h00, 0, 0,   32'h04, 1, 0, 0, 1);  // 3
        add(0, 0, 0, 32'h00, 0, 0,   32'h08, 1, 0, 0, 2);  // 4
        add(0, 1, 0, 32'h00, 0, 0,   32'h08, 1, 0, 0, 2);  // 5 stall x3
        add(0, 1, 0, 32'h00, 0, 0,   32'h08, 1, 0, 0, 2);  // 6
        add(0, 1, 0, 32'h00, 0, 0,   32'h08, 1, 0, 0, 2);  // 7
        add(0, 0, 0, 32'h00, 0, 0,   32'h0c, 1, 0, 0, 3);  // 8 release
        add(0, 1, 1, 32'h04, 0, 0,   32'h04, 1, 0, 0, 3);  // 9 redirect beats stall
        add(0, 0, 0, 32'h00, 0, 0,   32'h08, 1, 0, 0, 4);  // 10
        add(0, 0, 1, 32'h10, 1, 0,   32'h08, 0, 0, 0, 5);  // 11 halt beats redirect
        add(0, 0, 0, 32'h00, 0, 0,   32'h08, 0, 0, 0, 5);  // 12 hold in HALT
        add(0, 0, 0, 32'h00, 1, 1,   32'h08, 0, 0, 0, 5);  // 13 halt+resume stays
        add(0, 0, 0, 32'h00, 0, 1,   32'h0c, 1, 0, 0, 5);  // 14 resume -> pc+4
        add(0, 0, 1, 32'h06, 0, 0,   32'h0c, 0, 1, 0, 6);  // 15 misaligned
        add(0, 0, 0, 32'h00, 0, 0,   32'h0c, 0, 1, 0, 6);  // 16 FAULT terminal
        add(0, 0, 1, 32'h40, 0, 0,   32'h0c, 0, 1, 0, 6);  // 17 ignored in FAULT
        add(1, 0, 0, 32'h00, 0, 0,   32'h00, 0, 0, 0, 0);  // 18 rst clears
        add(0, 0, 0, 32'h00, 0, 0,   32'h00, 1, 0, 0, 0);  // 19
        add(0, 0, 1, 32'h40, 0, 0,   32'h00, 0, 0, 1, 1);  // 20 range redirect
        add(1, 0, 0, 32'h00, 0, 0,   32'h00, 0, 0, 0, 0);  // 21
        add(0, 0, 0, 32'h00, 0, 0,   32'h00, 1, 0, 0, 0);  // 22
        add(0, 0, 1, 32'h18, 0, 0,   32'h18, 1, 0, 0, 1);  // 23
        add(0, 0, 0, 32'h00, 0, 0,   32'h1c, 1, 0, 0, 2);  // 24 last word
        add(0, 0, 0, 32'h00, 0, 0,   32'h1c, 0, 0, 1, 3);  // 25 sequential overflow
        add(1, 0, 0, 32'h00, 0, 0,   32'h00, 0, 0, 0, 0);  // 26
        add(0, 0, 0, 32'h00, 0, 0,   32'h00, 1, 0, 0, 0);  // 27
        add(0, 0, 1, 32'h1c, 0, 0,   32'h1c, 1, 0, 0, 1);  // 28
        add(0, 0, 0, 32'h00, 1, 0,   32'h1c, 0, 0, 0, 2);  // 29 halt at last word
        add(0, 0, 0, 32'h00, 0, 1,   32'h1c, 0, 0, 1, 2);  // 30 resume overflows
        add(1, 0, 0, 32'h00, 0, 0,   32'h00, 0, 0, 0, 0);  // 31
        add(0, 0, 0, 32'h00, 0, 0,   32'h00, 1, 0, 0, 0);  // 32
        add(0, 0, 1, 32'h42, 0, 0,   32'h00, 0, 1, 0, 1);  // 33 misalign wins
        add(1, 0, 0, 32'h00, 0, 0,   32'h00, 0, 0, 0, 0);  // 34

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].tgt,
                  vecs[i].halt, vecs[i].resume);
            chk($sformatf("v%0d pc", i),       pc,  vecs[i].e_pc);
            chk($sformatf("v%0d pc_plus4", i), pc4, vecs[i].e_pc + 32'd4);
            chk($sformatf("v%0d pc_valid", i), {31'd0, vld}, {31'd0, vecs[i].e_vld});
            chk($sformatf("v%0d f_mis", i),    {31'd0, fm},  {31'd0, vecs[i].e_fm});
            chk($sformatf("v%0d f_rng", i),    {31'd0, fr},  {31'd0, vecs[i].e_fr});
            chk($sformatf("v%0d count", i),    cnt, vecs[i].e_cnt);
        end

        // Wrapping build: overflow past the last word returns to RESET_ADDR.
        drive(1, 0, 0, 32'h00, 0, 0);
        drive(0, 0, 0, 32'h00, 0, 0);
        chk("wrap boot pc", w_pc, 32'h0);
        drive(0, 0, 1, 32'h1c, 0, 0);
        chk("wrap redirect pc", w_pc, 32'h1c);
        drive(0, 0, 0, 32'h00, 0, 0);
        chk("wrap seq pc", w_pc, 32'h0);
        chk("wrap seq valid", {31'd0, w_vld}, 32'd1);
        chk("wrap seq f_rng", {31'd0, w_fr}, 32'd0);
        chk("wrap seq count", w_cnt, 32'd2);
        drive(0, 0, 1, 32'h1c, 0, 0);
        drive(0, 0, 0, 32'h00, 1, 0);
        chk("wrap halt valid", {31'd0, w_vld}, 32'd0);
        drive(0, 0, 0, 32'h00, 0, 1);
        chk("wrap resume pc", w_pc, 32'h0);
        chk("wrap resume valid", {31'd0, w_vld}, 32'd1);
        chk("wrap resume f_rng", {31'd0, w_fr}, 32'd0);
        chk("wrap pc_plus4", w_pc4, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
